// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared calculator datapath constants and bit-op encodings
package calc_pkg;

    localparam int DATA_W = 64;
    localparam int IDX_W  = 6;
    localparam int CNT_W  = 7;

    // 3-bit bit-manipulation operation encodings
    localparam logic [2:0] BOP_CLR  = 3'b000;
    localparam logic [2:0] BOP_SET  = 3'b001;
    localparam logic [2:0] BOP_GET  = 3'b010;
    localparam logic [2:0] BOP_PASS = 3'b011;
    localparam logic [2:0] BOP_TGL  = 3'b100;
    localparam logic [2:0] BOP_POPC = 3'b101;
    localparam logic [2:0] BOP_CLZ  = 3'b110;
    localparam logic [2:0] BOP_REV  = 3'b111;

    typedef logic [2:0] bop_t;

endpackage

// File: rtl/bit_count64.sv
// rtl/bit_count64.sv - combinational popcount and leading-zero count of a 64-bit word
module bit_count64
    import calc_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output logic [CNT_W-1:0]  popcount,
    output logic [CNT_W-1:0]  lzcount
);

    // Popcount partial sums, one array per tree level so no array feeds itself
    logic [1:0] pc0 [32];
    logic [2:0] pc1 [16];
    logic [3:0] pc2 [8];
    logic [4:0] pc3 [4];
    logic [5:0] pc4 [2];

    // Leading-zero counts per group; a group is all-zero exactly when its msb is set
    logic [1:0] lz0 [32];
    logic [2:0] lz1 [16];
    logic [3:0] lz2 [8];
    logic [4:0] lz3 [4];
    logic [5:0] lz4 [2];

    // Adder tree for popcount: pairs of bits, then pairwise sums of growing width
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            pc0[i] = {1'b0, data[2*i]} + {1'b0, data[2*i+1]};
        end
        for (int i = 0; i < 16; i++) begin
            pc1[i] = {1'b0, pc0[2*i]} + {1'b0, pc0[2*i+1]};
        end
        for (int i = 0; i < 8; i++) begin
            pc2[i] = {1'b0, pc1[2*i]} + {1'b0, pc1[2*i+1]};
        end
        for (int i = 0; i < 4; i++) begin
            pc3[i] = {1'b0, pc2[2*i]} + {1'b0, pc2[2*i+1]};
        end
        for (int i = 0; i < 2; i++) begin
            pc4[i] = {1'b0, pc3[2*i]} + {1'b0, pc3[2*i+1]};
        end
        popcount = {1'b0, pc4[0]} + {1'b0, pc4[1]};
    end

    // Tree encoder for leading zeros: if the upper half is all zero, add its width to the lower count
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            if (data[2*i+1]) begin
                lz0[i] = 2'd0;
            end else if (data[2*i]) begin
                lz0[i] = 2'd1;
            end else begin
                lz0[i] = 2'd2;
            end
        end
        for (int i = 0; i < 16; i++) begin
            if (lz0[2*i+1][1]) begin
                lz1[i] = 3'd2 + {1'b0, lz0[2*i]};
            end else begin
                lz1[i] = {1'b0, lz0[2*i+1]};
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (lz1[2*i+1][2]) begin
                lz2[i] = 4'd4 + {1'b0, lz1[2*i]};
            end else begin
                lz2[i] = {1'b0, lz1[2*i+1]};
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (lz2[2*i+1][3]) begin
                lz3[i] = 5'd8 + {1'b0, lz2[2*i]};
            end else begin
                lz3[i] = {1'b0, lz2[2*i+1]};
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (lz3[2*i+1][4]) begin
                lz4[i] = 6'd16 + {1'b0, lz3[2*i]};
            end else begin
                lz4[i] = {1'b0, lz3[2*i+1]};
            end
        end
        if (lz4[1][5]) begin
            lzcount = 7'd32 + {1'b0, lz4[0]};
        end else begin
            lzcount = {1'b0, lz4[1]};
        end
    end

endmodule

// File: rtl/int_bit_manip_unit.sv
// rtl/int_bit_manip_unit.sv - registered 64-bit integer bit-manipulation unit
module int_bit_manip_unit
    import calc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        operation,
    input  logic [DATA_W-1:0] opa,
    input  logic [DATA_W-1:0] opb,
    output logic [DATA_W-1:0] out
);

    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] rev;
    logic [DATA_W-1:0] result;
    logic [CNT_W-1:0]  popcount;
    logic [CNT_W-1:0]  lzcount;

    // Only the low bits of opb select a bit; the rest of the operand is ignored
    assign idx  = opb[IDX_W-1:0];
    assign mask = DATA_W'(1) << idx;

    // Bit reverse is pure wiring
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_rev
            assign rev[gi] = opa[DATA_W-1-gi];
        end
    endgenerate

    bit_count64 u_bit_count64 (
        .data     (opa),
        .popcount (popcount),
        .lzcount  (lzcount)
    );

    // Select the result of the requested operation
    always_comb begin
        result = '0;
        case (operation)
            BOP_CLR:  result = opa & ~mask;
            BOP_SET:  result = opa | mask;
            BOP_GET:  result = {{(DATA_W-1){1'b0}}, |(opa & mask)};
            BOP_PASS: result = opa;
            BOP_TGL:  result = opa ^ mask;
            BOP_POPC: result = {{(DATA_W-CNT_W){1'b0}}, popcount};
            BOP_CLZ:  result = {{(DATA_W-CNT_W){1'b0}}, lzcount};
            BOP_REV:  result = rev;
            default:  result = '0;
        endcase
    end

    // Result register; reset wins over any operation in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            out <= '0;
        end else begin
            out <= result;
        end
    end

endmodule

// File: tb/tb_int_bit_manip_unit.sv
// tb/tb_int_bit_manip_unit.sv - directed table-driven bench for int_bit_manip_unit
module tb_int_bit_manip_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  operation;
    logic [63:0] opa;
    logic [63:0] opb;
    logic [63:0] out;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [20];

    int_bit_manip_unit dut (
        .clk       (clk),
        .rst       (rst),
        .operation (operation),
        .opa       (opa),
        .opb       (opb),
        .out       (out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Drive inputs on the falling edge, then sample just after the next rising edge
    task automatic step(input logic r, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        rst       = r;
        operation = op;
        opa       = a;
        opb       = b;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        int          k;
        int          idx;
        idx = int'(b[5:0]);
        r   = 64'h0;
        case (op)
            3'd0: begin r = a; r[idx] = 1'b0; end
            3'd1: begin r = a; r[idx] = 1'b1; end
            3'd2: r = {63'h0, a[idx]};
            3'd3: r = a;
            3'd4: begin r = a; r[idx] = ~a[idx]; end
            3'd5: begin
                k = 0;
                for (int i = 0; i < 64; i++) k += int'(a[i]);
                r = 64'(k);
            end
            3'd6: begin
                k = 0;
                for (int i = 63; i >= 0; i--) begin
                    if (a[i]) break;
                    k++;
                end
                r = 64'(k);
            end
            default: for (int i = 0; i < 64; i++) r[i] = a[63-i];
        endcase
        return r;
    endfunction

    initial begin
        logic [63:0] ones;
        logic [2:0]  sop;
        logic        srst;
        ones = 64'hFFFF_FFFF_FFFF_FFFF;

        vecs[0]  = '{3'b001, 64'h0,                    64'd63,                   64'h8000_0000_0000_0000};
        vecs[1]  = '{3'b000, ones,                     64'd0,                    64'hFFFF_FFFF_FFFF_FFFE};
        vecs[2]  = '{3'b100, 64'h10,                   64'd4,                    64'h0};
        vecs[3]  = '{3'b001, 64'h0,                    64'hFFFF_FFFF_FFFF_FFC5,  64'h20};
        vecs[4]  = '{3'b010, 64'h100,                  64'd8,                    64'h1};
        vecs[5]  = '{3'b010, 64'h100,                  64'd9,                    64'h0};
        vecs[6]  = '{3'b101, ones,                     64'h0,                    64'd64};
        vecs[7]  = '{3'b101, 64'hF0F0,                 ones,                     64'd8};
        vecs[8]  = '{3'b110, 64'h0,                    64'h0,                    64'd64};
        vecs[9]  = '{3'b110, 64'h1,                    ones,                     64'd63};
        vecs[10] = '{3'b110, 64'h8000_0000_0000_0000,  64'h0,                    64'd0};
        vecs[11] = '{3'b111, 64'h1,                    64'h0,                    64'h8000_0000_0000_0000};
        vecs[12] = '{3'b111, 64'h1234_5678_9ABC_DEF0,  64'h0,                    64'h0F7B_3D59_1E6A_2C48};
        vecs[13] = '{3'b011, 64'hDEAD_BEEF_0123_4567,  ones,                     64'hDEAD_BEEF_0123_4567};
        vecs[14] = '{3'b101, 64'h0,                    64'h0,                    64'd0};
        vecs[15] = '{3'b110, 64'h0000_0001_0000_0000,  64'h0,                    64'd31};
        vecs[16] = '{3'b010, 64'h8000_0000_0000_0000,  64'hFFFF_FFFF_FFFF_FF3F,  64'h1};
        vecs[17] = '{3'b101, 64'h8000_0000_0000_0001,  64'h0,                    64'd2};
        vecs[18] = '{3'b100, 64'h0,                    64'd63,                   64'h8000_0000_0000_0000};
        vecs[19] = '{3'b000, 64'h8000_0000_0000_0001,  64'd63,                   64'h1};

        rst = 1'b1; operation = 3'b011; opa = ones; opb = 64'h0;

        // Reset holds out at zero even with a pass-through of all ones presented
        step(1'b1, 3'b011, ones, 64'h0);
        check("reset_0", out, 64'h0);
        step(1'b1, 3'b011, ones, 64'h0);
        check("reset_1", out, 64'h0);
        step(1'b0, 3'b011, ones, 64'h0);
        check("reset_release", out, ones);

        for (int i = 0; i < 20; i++) begin
            step(1'b0, vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d_op%0d", i, vecs[i].op), out, vecs[i].exp);
        end

        // Back-to-back stream cycling all operations, reset pulsed in the middle
        for (int c = 0; c < 20; c++) begin
            sop  = 3'(c % 8);
            srst = (c == 11);
            step(srst, sop, 64'h0000_00F0_0000_8421, 64'hABCD_0000_0000_0027);
            check($sformatf("stream%0d", c), out,
                  srst ? 64'h0 : model(sop, 64'h0000_00F0_0000_8421, 64'hABCD_0000_0000_0027));
        end

        // Stream with operands changing each cycle as well
        for (int c = 0; c < 8; c++) begin
            step(1'b0, 3'(7 - c), 64'h1 << (c * 9), 64'(c * 9));
            check($sformatf("vary%0d", c), out, model(3'(7 - c), 64'h1 << (c * 9), 64'(c * 9)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
